// File: rtl/bpu_pkg.sv
// Shared types, counter encodings and helpers for the fetch-side branch predictor.
package bpu_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned TAG_W = 30;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        BRANCH = 2'b01,
        JAL    = 2'b10,
        JALR   = 2'b11
    } ctrl_kind_t;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tags are stored zero-extended to TAG_W; unused upper bits stay constant zero.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   target;
        logic [1:0]        ctr;
        logic              is_jump;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
        else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch lookup, bru resolution and redirect signals between fetch/bru and the predictor.
interface btb_predictor_if #(
    parameter int unsigned CNT_W = 16
);
    import bpu_pkg::*;

    logic              fetch_valid;
    logic [PC_W-1:0]   fetch_pc;
    logic              flush;
    logic              pred_valid;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;

    logic              upd_valid;
    ctrl_kind_t        upd_kind;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_is_taken;
    logic [PC_W-1:0]   upd_pc_bru;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_target;

    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output fetch_valid, fetch_pc, flush,
        output upd_valid, upd_kind, upd_pc, upd_is_taken, upd_pc_bru,
        output upd_pred_taken, upd_pred_target,
        input  pred_valid, pred_taken, pred_target,
        input  mispredict, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc, flush,
        input  upd_valid, upd_kind, upd_pc, upd_is_taken, upd_pc_bru,
        input  upd_pred_taken, upd_pred_target,
        output pred_valid, pred_taken, pred_target,
        output mispredict, redirect_pc, mispredict_cnt
    );

endinterface

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one combinational read port, one clocked read-modify-write
// update port. Reads see pre-edge contents, so same-cycle read/write is read-before-write.
module btb_array
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output btb_entry_t        rd_entry_c,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  ctrl_kind_t        wr_kind,
    input  logic              wr_taken,
    input  logic [PC_W-1:0]   wr_target
);

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic             jump_q   [ENTRIES];

    logic wr_hit_c;
    logic wr_branch_c;

    always_comb begin
        rd_entry_c         = '0;
        rd_entry_c.valid   = valid_q[rd_idx];
        rd_entry_c.tag     = tag_q[rd_idx];
        rd_entry_c.target  = target_q[rd_idx];
        rd_entry_c.ctr     = ctr_q[rd_idx];
        rd_entry_c.is_jump = jump_q[rd_idx];
    end

    always_comb begin
        wr_hit_c    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        wr_branch_c = (wr_kind == BRANCH);
    end

    // Control state: valid bits and counters carry the reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (wr_en) begin
            if (wr_hit_c) begin
                ctr_q[wr_idx] <= wr_branch_c ? sat_ctr_next(ctr_q[wr_idx], wr_taken) : CTR_ST;
            end else if (wr_taken) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= wr_branch_c ? CTR_WT : CTR_ST;
            end
        end
    end

    // Payload state needs no reset; it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_hit_c) begin
                if (!wr_branch_c || wr_taken) target_q[wr_idx] <= wr_target;
                if (!wr_branch_c)             jump_q[wr_idx]   <= 1'b1;
            end else if (wr_taken) begin
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
                jump_q[wr_idx]   <= !wr_branch_c;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Fetch-side branch predictor: BTB lookup with 1-cycle latency, bru-driven training,
// and registered mispredict/redirect with a saturating mispredict counter.
module btb_predictor
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    btb_predictor_if.slave   bus
);

    localparam int unsigned TAG_SHIFT = IDX_W + 2;

    logic [IDX_W-1:0] fetch_idx_c;
    logic [TAG_W-1:0] fetch_tag_c;
    logic [IDX_W-1:0] upd_idx_c;
    logic [TAG_W-1:0] upd_tag_c;
    btb_entry_t       rd_entry_c;
    logic             lookup_taken_c;
    logic             upd_en_c;
    logic             mis_c;

    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [PC_W-1:0]  pred_target_q;
    logic             mispredict_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] mis_cnt_q;

    always_comb begin
        fetch_idx_c    = bus.fetch_pc[IDX_W+1:2];
        fetch_tag_c    = TAG_W'(bus.fetch_pc >> TAG_SHIFT);
        upd_idx_c      = bus.upd_pc[IDX_W+1:2];
        upd_tag_c      = TAG_W'(bus.upd_pc >> TAG_SHIFT);
        lookup_taken_c = rd_entry_c.valid && (rd_entry_c.tag == fetch_tag_c)
                         && (rd_entry_c.is_jump || rd_entry_c.ctr[1]);
        upd_en_c       = bus.upd_valid && (bus.upd_kind != NONE);
        mis_c          = (bus.upd_pred_taken != bus.upd_is_taken)
                         || (bus.upd_is_taken && (bus.upd_pred_target != bus.upd_pc_bru));
    end

    btb_array #(.ENTRIES(ENTRIES)) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (fetch_idx_c),
        .rd_entry_c (rd_entry_c),
        .wr_en      (upd_en_c),
        .wr_idx     (upd_idx_c),
        .wr_tag     (upd_tag_c),
        .wr_kind    (bus.upd_kind),
        .wr_taken   (bus.upd_is_taken),
        .wr_target  (bus.upd_pc_bru)
    );

    // Lookup result register; flush wins over fetch_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (bus.fetch_valid && !bus.flush) begin
            pred_valid_q  <= 1'b1;
            pred_taken_q  <= lookup_taken_c;
            pred_target_q <= lookup_taken_c ? rd_entry_c.target : bus.fetch_pc + PC_W'(4);
        end else begin
            pred_valid_q  <= 1'b0;
        end
    end

    // Redirect and statistics; independent of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            mis_cnt_q     <= '0;
        end else begin
            mispredict_q <= upd_en_c && mis_c;
            if (upd_en_c) begin
                redirect_pc_q <= bus.upd_is_taken ? bus.upd_pc_bru : bus.upd_pc + PC_W'(4);
                if (mis_c && (mis_cnt_q != {CNT_W{1'b1}})) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pred_valid     = pred_valid_q;
    assign bus.pred_taken     = pred_taken_q;
    assign bus.pred_target    = pred_target_q;
    assign bus.mispredict     = mispredict_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed vector bench for btb_predictor: table-driven training/lookup sequence,
// then counter saturation and asynchronous reset mid-stream.
module tb_btb_predictor;
    import bpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    btb_predictor_if #(.CNT_W(16)) bus ();

    btb_predictor #(.ENTRIES(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        fl;
        logic        uv;
        ctrl_kind_t  uk;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] ubru;
        logic        upt;
        logic [31:0] uptg;
        logic        epv;
        logic        ept;
        logic [31:0] eptg;
        logic        emis;
        logic [31:0] erd;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(logic fv, logic [31:0] fpc, logic fl,
                                logic uv, ctrl_kind_t uk, logic [31:0] upc, logic ut,
                                logic [31:0] ubru, logic upt, logic [31:0] uptg,
                                logic epv, logic ept, logic [31:0] eptg,
                                logic emis, logic [31:0] erd, logic [15:0] ecnt);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.fl = fl;
        v.uv = uv; v.uk = uk; v.upc = upc; v.ut = ut; v.ubru = ubru;
        v.upt = upt; v.uptg = uptg;
        v.epv = epv; v.ept = ept; v.eptg = eptg;
        v.emis = emis; v.erd = erd; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.fetch_valid     = v.fv;
        bus.fetch_pc        = v.fpc;
        bus.flush           = v.fl;
        bus.upd_valid       = v.uv;
        bus.upd_kind        = v.uk;
        bus.upd_pc          = v.upc;
        bus.upd_is_taken    = v.ut;
        bus.upd_pc_bru      = v.ubru;
        bus.upd_pred_taken  = v.upt;
        bus.upd_pred_target = v.uptg;
    endtask

    task automatic chk_all(input string tag, input logic pv, input logic pt, input logic [31:0] ptg,
                           input logic mis, input logic [31:0] rd, input logic [15:0] cnt);
        chk({tag, " pred_valid"},  32'(bus.pred_valid),     32'(pv));
        chk({tag, " pred_taken"},  32'(bus.pred_taken),     32'(pt));
        chk({tag, " pred_target"}, bus.pred_target,         ptg);
        chk({tag, " mispredict"},  32'(bus.mispredict),     32'(mis));
        chk({tag, " redirect_pc"}, bus.redirect_pc,         rd);
        chk({tag, " mis_cnt"},     32'(bus.mispredict_cnt), 32'(cnt));
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 32'h0, 0, 0, NONE, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 16'h0);

        //          fv fpc           fl uv kind    upc          ut bru           upt ptgt          pv pt ptg           mis rd            cnt
        vecs[0]  = mk(1, 32'h08,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 0, 32'h0C,       0, 32'h0,        16'd0);
        vecs[1]  = mk(0, 32'h0,        0, 1, BRANCH, 32'h08, 1, 32'h12345678, 0, 32'h0,        0, 0, 32'h0C,       1, 32'h12345678, 16'd1);
        vecs[2]  = mk(1, 32'h08,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 1, 32'h12345678, 0, 32'h12345678, 16'd1);
        vecs[3]  = mk(0, 32'h0,        0, 1, BRANCH, 32'h08, 0, 32'h0,        1, 32'h12345678, 0, 1, 32'h12345678, 1, 32'h0C,       16'd2);
        vecs[4]  = mk(0, 32'h0,        0, 1, BRANCH, 32'h08, 0, 32'h0,        1, 32'h12345678, 0, 1, 32'h12345678, 1, 32'h0C,       16'd3);
        vecs[5]  = mk(1, 32'h08,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 0, 32'h0C,       0, 32'h0C,       16'd3);
        vecs[6]  = mk(0, 32'h0,        0, 1, JALR,   32'h48, 1, 32'h12348AC6, 1, 32'h12348AC6, 0, 0, 32'h0C,       0, 32'h12348AC6, 16'd3);
        vecs[7]  = mk(1, 32'h08,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 0, 32'h0C,       0, 32'h12348AC6, 16'd3);
        vecs[8]  = mk(1, 32'h48,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 1, 32'h12348AC6, 0, 32'h12348AC6, 16'd3);
        vecs[9]  = mk(1, 32'h10,       0, 1, BRANCH, 32'h10, 1, 32'h200,      0, 32'h0,        1, 0, 32'h14,       1, 32'h200,      16'd4);
        vecs[10] = mk(1, 32'h10,       0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 1, 32'h200,      0, 32'h200,      16'd4);
        vecs[11] = mk(1, 32'h10,       1, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        0, 1, 32'h200,      0, 32'h200,      16'd4);
        vecs[12] = mk(1, 32'h10,       0, 1, JAL,    32'h10, 1, 32'h300,      1, 32'h200,      1, 1, 32'h200,      1, 32'h300,      16'd5);
        vecs[13] = mk(1, 32'h10,       0, 1, NONE,   32'h10, 1, 32'h999,      0, 32'h0,        1, 1, 32'h300,      0, 32'h300,      16'd5);
        vecs[14] = mk(0, 32'h0,        0, 0, BRANCH, 32'h10, 1, 32'h999,      0, 32'h0,        0, 1, 32'h300,      0, 32'h300,      16'd5);
        vecs[15] = mk(0, 32'h0,        0, 1, BRANCH, 32'h10, 0, 32'h0,        0, 32'h0,        0, 1, 32'h300,      0, 32'h14,       16'd5);
        vecs[16] = mk(1, 32'hFFFFFFFC, 0, 0, NONE,   32'h0,  0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h14,       16'd5);

        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 32'h0, 0, 32'h0, 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].epv, vecs[i].ept, vecs[i].eptg,
                    vecs[i].emis, vecs[i].erd, vecs[i].ecnt);
        end

        // Continuous not-taken branch at an unallocated PC, predicted taken: mispredict every cycle.
        drive(mk(0, 32'h0, 0, 1, BRANCH, 32'h20, 0, 32'h0, 1, 32'h0,
                 0, 0, 32'h0, 0, 32'h0, 16'h0));
        repeat (65529) @(posedge clk);
        #1;
        chk("sat cnt_fffe", 32'(bus.mispredict_cnt), 32'h0000FFFE);
        @(posedge clk);
        #1;
        chk("sat cnt_ffff", 32'(bus.mispredict_cnt), 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat cnt_hold", 32'(bus.mispredict_cnt), 32'h0000FFFF);
        chk("sat mispredict", 32'(bus.mispredict), 32'h1);
        chk("sat redirect", bus.redirect_pc, 32'h24);

        // Reset mid-stream while outputs are non-zero.
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h10;
        @(posedge clk);
        #1;
        chk_all("pre_rst", 1, 1, 32'h300, 1, 32'h24, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("in_rst", 0, 0, 32'h0, 0, 32'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1, 32'h10, 0, 0, NONE, 32'h0, 0, 32'h0, 0, 32'h0,
                 0, 0, 32'h0, 0, 32'h0, 16'h0));
        @(posedge clk);
        #1;
        chk_all("post_rst 0x10", 1, 0, 32'h14, 0, 32'h0, 16'h0);
        bus.fetch_pc = 32'h48;
        @(posedge clk);
        #1;
        chk_all("post_rst 0x48", 1, 0, 32'h4C, 0, 32'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
